// File: rtl/sel_pipe_mux.sv
// Registered N-input select mux with an output register plus a 1-entry skid buffer.
// Define SEL_PIPE_MUX_ERR_CNT_EN to add the saturating illegal-select counter port err_cnt.
module sel_pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH*NUM_IN-1:0] data_in,
    input  logic [SEL_W-1:0]        ctrl,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
`ifdef SEL_PIPE_MUX_ERR_CNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_legal;
    logic             accept;
    logic             drain;
    logic             err_set;

    // An out-of-range ctrl matches no input, leaving the zero default and sel_legal=0.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        sel_data  = '0;
        sel_legal = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ctrl == SEL_W'(k)) begin
                sel_data  = data_in[k*WIDTH +: WIDTH];
                sel_legal = 1'b1;
            end
        end
    end

    assign accept  = in_valid && in_ready_q;
    assign drain   = out_valid && out_ready;
    assign err_set = accept && !sel_legal;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = sel_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    out_d = sel_data;
                end else if (accept) begin
                    skid_d  = sel_data;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can occur.
                if (drain) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Registered ready looks ahead at the next state, so it never depends on out_ready combinationally.
        in_ready_d = (state_d != ST_FULL);
        sel_err_d  = err_set || (sel_err_q && !err_clr);
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking would race with other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            // NOTE: the skid register is reset too, so no stale data survives a mid-transfer reset.
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign data_out  = out_q;
    assign sel_err   = sel_err_q;

`ifdef SEL_PIPE_MUX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // A new illegal beat wins over err_clr, restarting the count at 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_set) begin
            if (err_clr)
                err_cnt_d = 8'd1;
            else if (err_cnt_q != 8'hFF)
                err_cnt_d = err_cnt_q + 8'd1;
        end else if (err_clr) begin
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= 8'd0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Directed self-checking bench for sel_pipe_mux (NUM_IN=3, WIDTH=32).
// Define SEL_PIPE_MUX_ERR_CNT_EN to also exercise the error counter.
module tb_sel_pipe_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [31:0] D2 = 32'h3333_3333;

    logic                    clk;
    logic                    rst_n;
    logic [WIDTH*NUM_IN-1:0] data_in;
    logic [SEL_W-1:0]        ctrl;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        data_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic                    err_clr;
`ifdef SEL_PIPE_MUX_ERR_CNT_EN
    logic [7:0]              err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    sel_pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .ctrl      (ctrl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
`ifdef SEL_PIPE_MUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        data_in   = {D2, D1, D0};
        ctrl      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_beat();
        ctrl      = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        total++; if (data_out !== D1) begin bad++; $display("FAIL single_data got=%h exp=%h", data_out, D1); end
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL single_sel_err got=%b exp=0", sel_err); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [SEL_W-1:0] seq [4];
        logic [31:0]      exp [4];
        seq = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp = '{D0, D1, D2, D0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctrl     = seq[i];
            in_valid = 1'b1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || data_out !== exp[i]) begin
                bad++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", i, out_valid, data_out, exp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl      = 2'd0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_1 got=%b exp=1", in_ready); end
        ctrl = 2'd1;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_after_2 got=%b exp=0", in_ready); end
        total++; if (data_out !== D0) begin bad++; $display("FAIL bp_head got=%h exp=%h", data_out, D0); end
        ctrl = 2'd2;
        tick();
        total++; if (out_valid !== 1'b1 || data_out !== D0) begin
            bad++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, data_out, D0);
        end
        out_ready = 1'b1;
        tick();
        total++; if (data_out !== D1) begin bad++; $display("FAIL bp_drain_1 got=%h exp=%h", data_out, D1); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_reopen got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || data_out !== D2) begin
            bad++; $display("FAIL bp_drain_2 got=%b/%h exp=1/%h", out_valid, data_out, D2);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal_sel();
        out_ready = 1'b1;
        ctrl      = 2'd3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || data_out !== 32'h0) begin
            bad++; $display("FAIL illegal_data got=%b/%h exp=1/0", out_valid, data_out);
        end
        total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL illegal_sel_err got=%b exp=1", sel_err); end
        tick();
        tick();
        total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b exp=1", sel_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b exp=0", sel_err); end
        err_clr  = 1'b1;
        in_valid = 1'b1;
        tick();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL illegal_set_wins got=%b exp=1", sel_err); end
        ctrl = 2'd2;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL illegal_final_clear got=%b exp=0", sel_err); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl      = 2'd1;
        tick();
        ctrl = 2'd2;
        tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rf_full got=%b exp=0", in_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || data_out !== 32'h0) begin
            bad++; $display("FAIL rf_immediate got=%b/%h exp=0/0", out_valid, data_out);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rf_in_ready got=%b exp=0", in_ready); end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_stale[%0d] got=%b exp=0", i, out_valid); end
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rf_ready_after got=%b exp=1", in_ready); end
    endtask

`ifdef SEL_PIPE_MUX_ERR_CNT_EN
    task automatic test_err_cnt();
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL cnt_start got=%0d exp=0", err_cnt); end
        out_ready = 1'b1;
        ctrl      = 2'd3;
        in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL cnt_saturate got=%0d exp=255", err_cnt); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL cnt_clear got=%0d exp=0", err_cnt); end
        in_valid = 1'b1;
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL cnt_set_wins got=%0d exp=1", err_cnt); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_illegal_sel();
        test_reset_full();
`ifdef SEL_PIPE_MUX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
